// File: rtl/ahb_lite_multi_master_arbiter_pkg.sv
// Shared bus types for the AHB-Lite arbiter and related fabric blocks.
//   HTRANS_state : AHB transfer type carried on each master's HTRANS
//   arb_state_t  : arbiter FSM encoding (ARB_IDLE / ARB_GRANT / ARB_HANDOVER)
//   ARB_FIXED / ARB_RR : arbitration mode selectors
package ahb_lite_multi_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE     = 2'd0;
  localparam arb_state_t ARB_GRANT    = 2'd1;
  localparam arb_state_t ARB_HANDOVER = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A master is asking for the bus only with an active transfer type;
  // BUSY merely keeps an existing grant alive.
  function automatic logic is_request(input HTRANS_state t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_lite_multi_master_arbiter_picker.sv
// arb_rr_picker: combinational winner selection over a request vector.
//   req    : one bit per requester
//   rr_ptr : first index considered when mode=1 (round-robin)
//   mode   : 0 = lowest index wins, 1 = first requester at/after rr_ptr (wrapping)
//   winner : selected index (0 when valid=0)
//   valid  : at least one requester present
module arb_rr_picker #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  input  logic           mode,
  output logic [IDW-1:0] winner,
  output logic           valid
);

  always_comb begin
    int start;
    int idx;
    winner = '0;
    valid  = 1'b0;
    start  = mode ? int'(rr_ptr) : 0;
    idx    = 0;
    // Walk all N slots once, starting at 'start' and wrapping at N.
    for (int i = 0; i < N; i++) begin
      idx = start + i;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_lite_multi_master_arbiter.sv
// ahb_lite_multi_master_arbiter: N-master AHB-Lite bus arbiter.
//   HCLK          : bus clock, all state on rising edge
//   HRESET        : synchronous active-high reset
//   i_HTRANS[i]   : transfer type of master i (NONSEQ/SEQ = request)
//   i_slave_done  : per-master end-of-burst pulse (only the owner's bit matters)
//   o_HREADY      : registered one-hot grant
//   o_grant_id    : index of current (or most recent) owner
//   o_bus_busy    : a master currently owns the bus
//   o_timeout     : one-cycle pulse when the watchdog alone forced a release
//   o_dbg_state   : current FSM state
//
// Handshake: a master raises its request (HTRANS NONSEQ/SEQ) and keeps it up;
// the grant is o_HREADY[i]=1, registered one cycle after the arbitration edge.
// The grant stays until the owner pulses done, drops HTRANS to IDLE, or the
// watchdog expires; then one dead cycle (ARB_HANDOVER) precedes re-arbitration.
module ahb_lite_multi_master_arbiter
  import ahb_lite_multi_master_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 3,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int WDW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  HTRANS_state          i_HTRANS [N_MASTERS],
  input  logic [N_MASTERS-1:0] i_slave_done,
  output logic [N_MASTERS-1:0] o_HREADY,
  output logic [IDW-1:0]       o_grant_id,
  output logic                 o_bus_busy,
  output logic                 o_timeout,
  output arb_state_t           o_dbg_state
);

  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES - 1);

  arb_state_t           state;
  logic [IDW-1:0]       rr_ptr;
  logic [WDW-1:0]       wdog;
  logic [N_MASTERS-1:0] req;
  logic [IDW-1:0]       pick_winner;
  logic                 pick_valid;
  logic                 rel_done;
  logic                 rel_abandon;
  logic                 rel_wdog;
  logic                 release_now;
  logic [IDW-1:0]       rr_next;

  always_comb begin
    req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      req[i] = is_request(i_HTRANS[i]);
    end
  end

  arb_rr_picker #(
    .N   (N_MASTERS),
    .IDW (IDW)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .mode   (1'(ARB_MODE == ARB_RR)),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // o_grant_id doubles as the owner register: it is only loaded on a grant.
  always_comb begin
    rel_done    = i_slave_done[o_grant_id];
    rel_abandon = (i_HTRANS[o_grant_id] == IDLE);
    rel_wdog    = (wdog == WD_MAX);
    release_now = rel_done || rel_abandon || rel_wdog;
    rr_next     = (o_grant_id == IDW'(N_MASTERS - 1)) ? '0 : o_grant_id + IDW'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ARB_IDLE;
      o_HREADY   <= '0;
      o_grant_id <= '0;
      o_bus_busy <= 1'b0;
      o_timeout  <= 1'b0;
      rr_ptr     <= '0;
      wdog       <= '0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          wdog <= '0;
          if (pick_valid) begin
            state      <= ARB_GRANT;
            o_HREADY   <= N_MASTERS'(1) << pick_winner;
            o_grant_id <= pick_winner;
            o_bus_busy <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            state      <= ARB_HANDOVER;
            o_HREADY   <= '0;
            o_bus_busy <= 1'b0;
            rr_ptr     <= rr_next;
            wdog       <= '0;
            // Flag only releases the watchdog caused on its own.
            o_timeout  <= rel_wdog && !rel_done && !rel_abandon;
          end else if (wdog != WD_MAX) begin
            wdog <= wdog + WDW'(1);
          end
        end
        ARB_HANDOVER: begin
          state <= ARB_IDLE;
          wdog  <= '0;
        end
        default: begin
          state      <= ARB_IDLE;
          o_HREADY   <= '0;
          o_bus_busy <= 1'b0;
          wdog       <= '0;
        end
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_ahb_lite_multi_master_arbiter.sv
// Bench for ahb_lite_multi_master_arbiter: a round-robin and a fixed-priority
// instance share the same master inputs; each is compared every cycle against
// a per-instance reference model of the arbitration rules.
module tb_ahb_lite_multi_master_arbiter;
  import ahb_lite_multi_master_arbiter_pkg::*;

  localparam int N = 3;
  localparam int T = 8;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  HTRANS_state htrans [N];
  logic [N-1:0] done;

  logic [N-1:0] hr_rr, hr_fx;
  logic [1:0]   gid_rr, gid_fx;
  logic         busy_rr, busy_fx, to_rr, to_fx;
  arb_state_t   st_rr, st_fx;

  ahb_lite_multi_master_arbiter #(
    .N_MASTERS(N), .ARB_MODE(ARB_RR), .TIMEOUT_CYCLES(T)
  ) dut_rr (
    .HCLK(HCLK), .HRESET(HRESET), .i_HTRANS(htrans), .i_slave_done(done),
    .o_HREADY(hr_rr), .o_grant_id(gid_rr), .o_bus_busy(busy_rr),
    .o_timeout(to_rr), .o_dbg_state(st_rr)
  );

  ahb_lite_multi_master_arbiter #(
    .N_MASTERS(N), .ARB_MODE(ARB_FIXED), .TIMEOUT_CYCLES(T)
  ) dut_fx (
    .HCLK(HCLK), .HRESET(HRESET), .i_HTRANS(htrans), .i_slave_done(done),
    .o_HREADY(hr_fx), .o_grant_id(gid_fx), .o_bus_busy(busy_fx),
    .o_timeout(to_fx), .o_dbg_state(st_fx)
  );

  // ---------------- reference model (index 0 = RR, 1 = fixed) ----------------
  int   m_owner [2];   // -1 when nobody owns the bus
  int   m_held  [2];   // granted cycles so far, counting the current one
  int   m_dead  [2];   // dead cycles left before arbitration resumes
  int   m_last  [2];   // last granted master
  int   m_ptr   [2];   // round-robin start index
  logic m_to    [2];

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];
  logic       recording = 1'b0;
  logic       prev_busy_rr = 1'b0;

  task automatic model_reset(input int d);
    m_owner[d] = -1; m_held[d] = 0; m_dead[d] = 0;
    m_last[d] = 0; m_ptr[d] = 0; m_to[d] = 1'b0;
  endtask

  task automatic model_step(input int d);
    int o;
    logic a, b, c;
    if (HRESET) begin
      model_reset(d);
      return;
    end
    m_to[d] = 1'b0;
    if (m_owner[d] >= 0) begin
      o = m_owner[d];
      a = done[o];
      b = (htrans[o] == IDLE);
      c = (m_held[d] >= T);
      if (a || b || c) begin
        m_to[d]    = c && !a && !b;
        m_ptr[d]   = (o + 1) % N;
        m_owner[d] = -1;
        m_dead[d]  = 1;
      end else begin
        m_held[d]++;
      end
    end else if (m_dead[d] > 0) begin
      m_dead[d]--;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = ((d == 0 ? m_ptr[d] : 0) + k) % N;
        if (m_owner[d] < 0 && (htrans[idx] == NONSEQ || htrans[idx] == SEQ)) begin
          m_owner[d] = idx;
          m_held[d]  = 1;
          m_last[d]  = idx;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] e_hr, e_st;
      e_hr = (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0;
      e_st = (m_owner[d] >= 0) ? 32'(ARB_GRANT) :
             (m_dead[d] > 0)   ? 32'(ARB_HANDOVER) : 32'(ARB_IDLE);
      if (d == 0) begin
        chk("rr_hready",  32'(hr_rr),   e_hr);
        chk("rr_grantid", 32'(gid_rr),  32'(m_last[0]));
        chk("rr_busy",    32'(busy_rr), 32'(m_owner[0] >= 0));
        chk("rr_timeout", 32'(to_rr),   32'(m_to[0]));
        chk("rr_state",   32'(st_rr),   e_st);
      end else begin
        chk("fx_hready",  32'(hr_fx),   e_hr);
        chk("fx_grantid", 32'(gid_fx),  32'(m_last[1]));
        chk("fx_busy",    32'(busy_fx), 32'(m_owner[1] >= 0));
        chk("fx_timeout", 32'(to_fx),   32'(m_to[1]));
        chk("fx_state",   32'(st_fx),   e_st);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model advances on the edge, outputs checked 1ns later,
  // done pulses are cleared so each pulse lasts a single cycle.
  task automatic step();
    @(posedge HCLK);
    model_step(0);
    model_step(1);
    #1;
    check_all();
    if (recording && busy_rr && !prev_busy_rr) got_q.push_back(gid_rr);
    prev_busy_rr = busy_rr;
    done = '0;
  endtask

  task automatic all_idle();
    for (int i = 0; i < N; i++) htrans[i] = IDLE;
    done = '0;
  endtask

  task automatic do_reset(input int n);
    HRESET = 1'b1;
    repeat (n) step();
    HRESET = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt, pulses, cnt0, cnt2;
    HRESET = 1'b1;
    all_idle();
    model_reset(0);
    model_reset(1);

    // Reset values, then single request from master 1 at cycle 5.
    do_reset(3);
    step();
    htrans[1] = NONSEQ;
    step();
    chk("single_hready", 32'(hr_rr), 32'h2);
    chk("single_gid",    32'(gid_rr), 32'd1);
    htrans[1] = SEQ;
    repeat (3) step();
    done[1] = 1'b1;
    step();
    chk("single_release", 32'(hr_rr), 32'h0);
    htrans[1] = IDLE;
    step();
    chk("single_idle", 32'(st_rr), 32'(ARB_IDLE));

    // Round-robin fairness: all request, owner done after 4 granted cycles.
    all_idle();
    do_reset(2);
    for (int i = 0; i < N; i++) htrans[i] = SEQ;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    got_q.delete();
    recording = 1'b1;
    for (int c = 0; c < 80 && got_q.size() < 6; c++) begin
      step();
      if (m_owner[0] >= 0 && m_held[0] == 4) done[m_owner[0]] = 1'b1;
    end
    recording = 1'b0;
    chk("rr_order_len", 32'(got_q.size()), 32'd6);
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("rr_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));

    // Fixed priority: masters 0 and 2 request continuously.
    all_idle();
    do_reset(2);
    htrans[0] = SEQ;
    htrans[2] = NONSEQ;
    cnt0 = 0;
    cnt2 = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (busy_fx && gid_fx == 2'd0) cnt0++;
      if (busy_fx && gid_fx == 2'd2) cnt2++;
      if (m_owner[1] == 0 && m_held[1] == 3) done[0] = 1'b1;
    end
    chk("fixed_never_2", 32'(cnt2), 32'd0);
    chk("fixed_owns_0",  32'(cnt0 > 0), 32'd1);

    // Watchdog: master 0 holds SEQ without done.
    all_idle();
    do_reset(2);
    htrans[0] = SEQ;
    cnt = 0;
    pulses = 0;
    for (int c = 0; c < 20 && pulses == 0; c++) begin
      step();
      if (hr_rr[0]) cnt++;
      if (to_rr) pulses++;
    end
    htrans[0] = IDLE;
    chk("wdog_len",   32'(cnt), 32'd8);
    chk("wdog_pulse", 32'(pulses), 32'd1);
    repeat (3) step();

    // Watchdog coincident with done on the 8th granted cycle: no timeout.
    htrans[0] = SEQ;
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (to_rr) pulses++;
      if (m_owner[0] == 0 && m_held[0] == 8) done[0] = 1'b1;
    end
    chk("wdog_done_no_to", 32'(pulses), 32'd0);

    // Stray done from a non-owner, then abandon by the owner.
    all_idle();
    do_reset(2);
    htrans[1] = SEQ;
    repeat (2) step();
    done[2] = 1'b1;
    step();
    chk("stray_done_hold", 32'(hr_rr), 32'h2);
    htrans[1] = IDLE;
    step();
    chk("abandon_release", 32'(hr_rr), 32'h0);
    chk("abandon_no_to",   32'(to_rr), 32'd0);
    repeat (2) step();

    // Reset mid-grant: rr_ptr left at 2 by releasing master 1, then reset.
    htrans[1] = SEQ;
    step();
    done[1] = 1'b1;
    step();
    repeat (3) step();
    htrans[2] = SEQ;
    HRESET = 1'b1;
    step();
    chk("midreset_hready", 32'(hr_rr), 32'h0);
    chk("midreset_busy",   32'(busy_rr), 32'd0);
    HRESET = 1'b0;
    step();
    chk("post_reset_gid", 32'(gid_rr), 32'd1);
    all_idle();
    repeat (3) step();

    // Randomised traffic.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 9);
        htrans[i] = (r == 0) ? IDLE : (r == 1) ? BUSY : (r < 6) ? NONSEQ : SEQ;
        done[i]   = ($urandom_range(0, 7) == 0);
      end
      HRESET = ($urandom_range(0, 99) == 0);
      step();
    end
    HRESET = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
